// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, scan states and keymap shared by the keypad scanner
package calc_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Indexed [row][col]; row 0 is the top row of the keypad.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{KEY_1,    KEY_2, KEY_3,    KEY_A},
        '{KEY_4,    KEY_5, KEY_6,    KEY_B},
        '{KEY_7,    KEY_8, KEY_9,    KEY_C},
        '{KEY_STAR, KEY_0, KEY_HASH, KEY_D}
    };

    // Moves the single driven (low) column one position up, wrapping 3 -> 0.
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick at the end of each slot
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    // Count 0..DIV-1 and wrap; the last count of the slot is the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with debounce and one strobe per press
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    row_meta;
    logic [3:0]    rs;
    logic          tick;
    scan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    row_l, row_l_n;
    logic [1:0]    col_l, col_l_n;
    logic [3:0]    col_n;
    logic [3:0]    code_n;
    logic          held_n;
    logic          valid_n;
    logic          any_low;
    logic [1:0]    low_idx;
    logic [1:0]    col_idx;

    tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchroniser; resets to the idle (all pulled-up) pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Lowest-index low row wins when several rows are pulled low together.
    always_comb begin
        any_low = (rs != 4'hF);
        low_idx = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (!rs[r]) low_idx = 2'(r);
    end

    // Index of the column currently being driven low.
    always_comb begin
        col_idx = 2'd0;
        for (int c = 0; c < 4; c++)
            if (!col[c]) col_idx = 2'(c);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            cnt       <= '0;
            col       <= 4'b1110;
            row_l     <= 2'd0;
            col_l     <= 2'd0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            col       <= col_n;
            row_l     <= row_l_n;
            col_l     <= col_l_n;
            key_code  <= code_n;
            key_held  <= held_n;
            key_valid <= valid_n;
        end
    end

    // Scan / debounce decisions, taken only on the slot tick.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        col_n   = col;
        row_l_n = row_l;
        col_l_n = col_l;
        code_n  = key_code;
        held_n  = key_held;
        valid_n = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!any_low) begin
                        col_n = rotate_col(col);
                    end else begin
                        row_l_n = low_idx;
                        col_l_n = col_idx;
                        cnt_n   = CNT_ONE;
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && low_idx == row_l) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            code_n  = KEYMAP[row_l][col_l];
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = HELD;
                        end
                    end else begin
                        cnt_n   = '0;
                        col_n   = rotate_col(col);
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (!any_low) begin
                        cnt_n   = CNT_ONE;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!any_low) begin
                        if (cnt == CNT_LAST) begin
                            cnt_n   = '0;
                            held_n  = 1'b0;
                            col_n   = rotate_col(col);
                            state_n = SCAN;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else if (!rs[row_l]) begin
                        cnt_n   = '0;
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - randomized slot-level bench for keypad_scan with a keypad model
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int passed = 0;
    int valid_cycles = 0;

    // Reference model state: what a user of the keypad would expect, slot by slot.
    int         m_mode;      // 0 scanning, 1 confirming, 2 held, 3 releasing
    int         m_col;
    int         m_row;
    int         m_cnt;
    logic [3:0] m_code;
    bit         m_held;
    int         m_strobes = 0;

    string labels = "123A456B789C*0#D";

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Strobe width tracking: total high cycles must equal the number of accepted presses.
    always @(negedge clk) if (key_valid === 1'b1) valid_cycles++;

    function automatic logic [15:0] key_mask(input int r, input int c);
        return 16'(1) << (r*4 + c);
    endfunction

    function automatic logic [3:0] label_code(input byte ch);
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
        if (ch == "*") return 4'hE;
        return 4'hF;
    endfunction

    function automatic int lowest_visible(input logic [15:0] p, input int c);
        for (int r = 0; r < 4; r++)
            if (p[r*4+c]) return r;
        return 4;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0; m_code = 4'h0; m_held = 0;
    endtask

    task automatic model_slot(input logic [15:0] p, output bit strobe);
        int lo;
        lo = lowest_visible(p, m_col);
        strobe = 0;
        case (m_mode)
            0: if (lo == 4) m_col = (m_col + 1) % 4;
               else begin m_row = lo; m_cnt = 1; m_mode = 1; end
            1: if (lo == m_row) begin
                   m_cnt++;
                   if (m_cnt == DEBOUNCE_CNT) begin
                       m_code = label_code(labels[m_row*4 + m_col]);
                       m_held = 1; m_mode = 2; strobe = 1; m_strobes++;
                   end
               end else begin
                   m_mode = 0; m_col = (m_col + 1) % 4;
               end
            2: if (lo == 4) begin m_mode = 3; m_cnt = 1; end
            default: if (lo == 4) begin
                   m_cnt++;
                   if (m_cnt == DEBOUNCE_CNT) begin
                       m_held = 0; m_mode = 0; m_col = (m_col + 1) % 4;
                   end
               end else if (p[m_row*4 + m_col]) begin
                   m_mode = 2;
               end
        endcase
    endtask

    // One scan slot: apply the key set early in the slot, then compare right after the tick.
    task automatic run_slot(input logic [15:0] p, output bit got_valid);
        bit         strobe;
        logic [3:0] exp_col;
        @(negedge clk);
        pressed = p;
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        model_slot(p, strobe);
        exp_col = ~(4'(1) << m_col);
        got_valid = key_valid;
        checks++;
        if (col !== exp_col) $display("FAIL slot_col got %b exp %b", col, exp_col);
        else passed++;
        checks++;
        if (key_valid !== strobe) $display("FAIL slot_valid got %b exp %b", key_valid, strobe);
        else passed++;
        checks++;
        if (key_held !== m_held) $display("FAIL slot_held got %b exp %b", key_held, m_held);
        else passed++;
        checks++;
        if (key_code !== m_code) $display("FAIL slot_code got %h exp %h", key_code, m_code);
        else passed++;
    endtask

    task automatic idle_slots(input int n);
        bit v;
        for (int i = 0; i < n; i++) run_slot(16'h0, v);
    endtask

    task automatic test_reset();
        bit v;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_outputs got %b %h %b %b", col, key_code, key_valid, key_held);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            run_slot(16'h0, v);
            if (i == 3) begin
                checks++;
                if (col !== 4'b1110) $display("FAIL scan_wrap got %b exp 1110", col);
                else passed++;
            end
        end
    endtask

    task automatic test_hold_five();
        bit v;
        int seen = 0;
        for (int i = 0; i < 20; i++) begin run_slot(key_mask(1, 1), v); seen += int'(v); end
        checks++;
        if (seen != 1 || key_code !== 4'h5 || col !== 4'b1101 || key_held !== 1'b1)
            $display("FAIL hold_five got seen=%0d code=%h col=%b held=%b exp 1 5 1101 1", seen, key_code, col, key_held);
        else passed++;
        idle_slots(4);
        checks++;
        if (key_held !== 1'b0) $display("FAIL hold_five_release got %b exp 0", key_held);
        else passed++;
    endtask

    task automatic test_glitch();
        bit v;
        for (int i = 0; i < 8 && m_col != 1; i++) run_slot(16'h0, v);
        checks++;
        if (col !== 4'b1101) $display("FAIL glitch_align got %b exp 1101", col);
        else passed++;
        run_slot(key_mask(1, 1), v);
        checks++;
        if (col !== 4'b1101 || v !== 1'b0) $display("FAIL glitch_freeze got col=%b valid=%b exp 1101 0", col, v);
        else passed++;
        run_slot(16'h0, v);
        checks++;
        if (col !== 4'b1011 || v !== 1'b0) $display("FAIL glitch_resume got col=%b valid=%b exp 1011 0", col, v);
        else passed++;
    endtask

    task automatic test_release_bounce();
        bit v;
        int seen = 0;
        for (int i = 0; i < 10; i++) begin run_slot(key_mask(3, 2), v); seen += int'(v); end
        run_slot(16'h0, v);          seen += int'(v);
        run_slot(key_mask(3, 2), v); seen += int'(v);
        for (int i = 0; i < 3; i++) begin
            run_slot(16'h0, v);
            seen += int'(v);
            checks++;
            if (key_held !== (i < 2)) $display("FAIL bounce_held slot %0d got %b exp %b", i, key_held, (i < 2));
            else passed++;
        end
        checks++;
        if (seen != 1 || key_code !== 4'hF) $display("FAIL bounce_strobe got seen=%0d code=%h exp 1 f", seen, key_code);
        else passed++;
    endtask

    task automatic test_two_keys();
        bit v;
        int seen = 0;
        for (int i = 0; i < 10; i++) begin run_slot(key_mask(3, 0) | key_mask(1, 0), v); seen += int'(v); end
        checks++;
        if (seen != 1 || key_code !== 4'h4) $display("FAIL two_keys got seen=%0d code=%h exp 1 4", seen, key_code);
        else passed++;
        idle_slots(4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin run_slot(key_mask(3, 0), v); seen += int'(v); end
        checks++;
        if (seen != 1 || key_code !== 4'hE) $display("FAIL star_alone got seen=%0d code=%h exp 1 e", seen, key_code);
        else passed++;
        idle_slots(4);
    endtask

    task automatic test_reset_mid();
        bit v;
        int seen = 0;
        for (int i = 0; i < 10; i++) run_slot(key_mask(2, 2), v);
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'h9) $display("FAIL mid_pre got held=%b code=%h exp 1 9", key_held, key_code);
        else passed++;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL mid_reset got %b %h %b %b", col, key_code, key_valid, key_held);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin run_slot(key_mask(2, 2), v); seen += int'(v); end
        checks++;
        if (seen != 1 || key_code !== 4'h9) $display("FAIL mid_redetect got seen=%0d code=%h exp 1 9", seen, key_code);
        else passed++;
        idle_slots(4);
    endtask

    task automatic test_random();
        bit          v;
        logic [15:0] p;
        int          kind;
        int          dur;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            p = 16'h0;
            if (kind >= 4) p = key_mask($urandom_range(0, 3), $urandom_range(0, 3));
            if (kind == 9) p = p | key_mask($urandom_range(0, 3), $urandom_range(0, 3));
            dur = $urandom_range(1, 5);
            for (int i = 0; i < dur; i++) run_slot(p, v);
        end
        idle_slots(4);
        checks++;
        if (valid_cycles != m_strobes) $display("FAIL strobe_width got %0d cycles exp %0d", valid_cycles, m_strobes);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_five();
        test_glitch();
        test_release_bounce();
        test_two_keys();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
